// File: rtl/sbit_deser_pkg.sv
// Shared constants and slice-index helpers for the s-bit frame deserializer.
// The index functions define the lane and frame bit layout for RTL and bench alike.
package sbit_deser_pkg;

  localparam int NUM_VFATS_DFLT = 24;
  localparam int LANE_W_DFLT    = 16;
  localparam int RATIO_DFLT     = 4;

  localparam int                  RESYNC_W   = 8;
  localparam logic [RESYNC_W-1:0] RESYNC_MAX = '1;

  // LSB of lane v within the packed lanes_i bus.
  function automatic int lane_lsb(input int v, input int lane_w);
    return v * lane_w;
  endfunction

  // LSB of beat b of VFAT v within the packed frame bus.
  function automatic int frame_lsb(input int v, input int b, input int lane_w, input int ratio);
    return (v * ratio + b) * lane_w;
  endfunction

endpackage

// File: rtl/sbit_lane_gearbox.sv
// One VFAT lane: masks each incoming beat, parks beats 0..RATIO-2 in slot
// registers and assembles the full frame when the top asserts capture_i.
module sbit_lane_gearbox
  import sbit_deser_pkg::*;
#(
  parameter int LANE_W = LANE_W_DFLT,
  parameter int RATIO  = RATIO_DFLT,
  parameter int CNT_W  = $clog2(RATIO)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CNT_W-1:0]        beat_i,
  input  logic                    capture_i,
  input  logic                    mask_i,
  input  logic [LANE_W-1:0]       lane_i,
  output logic [LANE_W*RATIO-1:0] frame_o
);

  logic [LANE_W-1:0]       lane_m;
  logic [LANE_W-1:0]       slot_q [RATIO-1];
  logic [LANE_W-1:0]       slot_d [RATIO-1];
  logic [LANE_W*RATIO-1:0] frame_asm;
  logic [LANE_W*RATIO-1:0] frame_q;
  logic [LANE_W*RATIO-1:0] frame_d;

  // The last beat is never parked: it goes straight into the assembled frame.
  always_comb begin
    lane_m    = mask_i ? '0 : lane_i;
    frame_asm = '0;
    for (int b = 0; b < RATIO - 1; b++) begin
      slot_d[b] = (beat_i == CNT_W'(b)) ? lane_m : slot_q[b];
      frame_asm[frame_lsb(0, b, LANE_W, RATIO) +: LANE_W] = slot_q[b];
    end
    frame_asm[frame_lsb(0, RATIO - 1, LANE_W, RATIO) +: LANE_W] = lane_m;
    frame_d = capture_i ? frame_asm : frame_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < RATIO - 1; b++) begin
        slot_q[b] <= '0;
      end
      frame_q <= '0;
    end else begin
      for (int b = 0; b < RATIO - 1; b++) begin
        slot_q[b] <= slot_d[b];
      end
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/sbit_frame_deserializer.sv
// S-bit front end: beat counter, frame-marker alignment and lock, resync
// counter, programmable-phase latch strobe, and one gearbox per VFAT.
module sbit_frame_deserializer
  import sbit_deser_pkg::*;
#(
  parameter int NUM_VFATS = NUM_VFATS_DFLT,
  parameter int LANE_W    = LANE_W_DFLT,
  parameter int RATIO     = RATIO_DFLT,
  parameter int CNT_W     = $clog2(RATIO)
) (
  input  logic                              clock4x,
  input  logic                              reset_n,
  input  logic                              frame_sync_i,
  input  logic [CNT_W-1:0]                  phase_i,
  input  logic [NUM_VFATS-1:0]              vfat_mask_i,
  input  logic [NUM_VFATS*LANE_W-1:0]       lanes_i,
  input  logic                              resync_clr_i,
  output logic [NUM_VFATS*LANE_W*RATIO-1:0] sbits_o,
  output logic                              valid_o,
  output logic                              latch_o,
  output logic                              locked_o,
  output logic [RESYNC_W-1:0]               resync_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                locked_q, locked_d;
  logic                valid_q, valid_d;
  logic [RESYNC_W-1:0] resync_q, resync_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]    elap_q, elap_d;
  logic                pend_q, pend_d;
  logic                misalign;
  logic                capture;
  logic                latch_now;
  logic [CNT_W-1:0]    wr_beat;

  // valid_o has no ready: it is a one-cycle pulse, and sbits_o holds its
  // value until the next completed frame overwrites it.
  always_comb begin
    misalign = frame_sync_i && locked_q && (beat_q != '0);
    wr_beat  = frame_sync_i ? '0 : beat_q;
    capture  = locked_q && (wr_beat == LAST_BEAT);
    beat_d   = frame_sync_i ? CNT_W'(1) : beat_q + CNT_W'(1);
    locked_d = locked_q | frame_sync_i;
    valid_d  = capture;

    if (resync_clr_i) begin
      resync_d = misalign ? RESYNC_W'(1) : '0;
    end else if (misalign && (resync_q != RESYNC_MAX)) begin
      resync_d = resync_q + RESYNC_W'(1);
    end else begin
      resync_d = resync_q;
    end

    // Phase 0 strobes in the valid_o cycle itself; otherwise count cycles since it.
    latch_now = (valid_q && (phase_i == '0)) || (pend_q && (elap_q == phase_q));
    phase_d   = phase_q;
    elap_d    = elap_q;
    pend_d    = pend_q;
    if (valid_q) begin
      phase_d = phase_i;
      elap_d  = CNT_W'(1);
      pend_d  = (phase_i != '0);
    end else if (pend_q) begin
      elap_d = elap_q + CNT_W'(1);
      if (latch_now || misalign) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      beat_q   <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      resync_q <= '0;
      phase_q  <= '0;
      elap_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      resync_q <= resync_d;
      phase_q  <= phase_d;
      elap_q   <= elap_d;
      pend_q   <= pend_d;
    end
  end

  for (genvar v = 0; v < NUM_VFATS; v++) begin : g_lane
    sbit_lane_gearbox #(
      .LANE_W (LANE_W),
      .RATIO  (RATIO),
      .CNT_W  (CNT_W)
    ) u_gearbox (
      .clk_i     (clock4x),
      .rst_ni    (reset_n),
      .beat_i    (wr_beat),
      .capture_i (capture),
      .mask_i    (vfat_mask_i[v]),
      .lane_i    (lanes_i[lane_lsb(v, LANE_W) +: LANE_W]),
      .frame_o   (sbits_o[frame_lsb(v, 0, LANE_W, RATIO) +: LANE_W*RATIO])
    );
  end

  assign valid_o      = valid_q;
  assign latch_o      = latch_now;
  assign locked_o     = locked_q;
  assign resync_cnt_o = resync_q;

endmodule

// File: tb/tb_sbit_frame_deserializer.sv
// Bench for sbit_frame_deserializer: directed and random stimulus checked
// against a frame-level model, plus a second 8x8x8 instance for layout/period.
module tb_sbit_frame_deserializer;
  import sbit_deser_pkg::*;

  localparam int NV = 24;
  localparam int LW = 16;
  localparam int R  = 4;
  localparam int CW = 2;
  localparam int SW = LW * R;

  localparam int NV2 = 8;
  localparam int LW2 = 8;
  localparam int R2  = 8;
  localparam int CW2 = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              sync  = 1'b0;
  logic              clr   = 1'b0;
  logic [CW-1:0]     phase = '0;
  logic [NV-1:0]     mask  = '0;
  logic [NV*LW-1:0]  lanes = '0;
  logic [NV*SW-1:0]  sbits;
  logic              valid, latch, locked;
  logic [7:0]        rcnt;

  logic                  sync2  = 1'b0;
  logic                  clr2   = 1'b0;
  logic [CW2-1:0]        phase2 = '0;
  logic [NV2-1:0]        mask2  = '0;
  logic [NV2*LW2-1:0]    lanes2 = '0;
  logic [NV2*LW2*R2-1:0] sbits2;
  logic                  valid2, latch2, locked2;
  logic [7:0]            rcnt2;

  sbit_frame_deserializer #(.NUM_VFATS(NV), .LANE_W(LW), .RATIO(R)) dut (
    .clock4x(clk), .reset_n(rst_n), .frame_sync_i(sync), .phase_i(phase),
    .vfat_mask_i(mask), .lanes_i(lanes), .resync_clr_i(clr), .sbits_o(sbits),
    .valid_o(valid), .latch_o(latch), .locked_o(locked), .resync_cnt_o(rcnt)
  );

  sbit_frame_deserializer #(.NUM_VFATS(NV2), .LANE_W(LW2), .RATIO(R2)) dut8 (
    .clock4x(clk), .reset_n(rst_n), .frame_sync_i(sync2), .phase_i(phase2),
    .vfat_mask_i(mask2), .lanes_i(lanes2), .resync_clr_i(clr2), .sbits_o(sbits2),
    .valid_o(valid2), .latch_o(latch2), .locked_o(locked2), .resync_cnt_o(rcnt2)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  bit              m_locked, m_valid, m_pend;
  int              m_pos, m_cnt, m_due;
  logic [LW-1:0]   m_hold [NV][R];
  logic [SW-1:0]   m_frame [NV];
  logic [SW-1:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_valid = 0; m_pend = 0;
    m_pos = 0; m_cnt = 0; m_due = 0;
    for (int v = 0; v < NV; v++) begin
      m_frame[v] = '0;
      for (int b = 0; b < R; b++) m_hold[v][b] = '0;
    end
    exp_q.delete();
  endtask

  function automatic logic [NV*LW-1:0] pat(input int b);
    logic [NV*LW-1:0] r;
    for (int v = 0; v < NV; v++) r[lane_lsb(v, LW) +: LW] = {8'(v), 8'(b)};
    return r;
  endfunction

  function automatic logic [NV*LW-1:0] rnd_lanes();
    logic [NV*LW-1:0] r;
    for (int v = 0; v < NV; v++) r[lane_lsb(v, LW) +: LW] = 16'($urandom);
    return r;
  endfunction

  function automatic logic [NV2*LW2-1:0] pat2(input int b);
    logic [NV2*LW2-1:0] r;
    for (int v = 0; v < NV2; v++) r[lane_lsb(v, LW2) +: LW2] = {4'(v), 4'(b)};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: drive inputs, check the latch strobe, advance the model, then
  // check registered outputs after the edge.
  task automatic cyc(input bit s, input logic [NV-1:0] mk, input bit c,
                     input logic [CW-1:0] ph, input logic [NV*LW-1:0] ln);
    int b;
    bit mis;
    bit exp_latch;
    logic [SW-1:0] f;
    sync = s; mask = mk; clr = c; phase = ph; lanes = ln;
    #1;
    if (m_valid) begin
      m_pend = 1;
      m_due  = cyc_n + int'(ph);
    end
    exp_latch = m_pend && (cyc_n == m_due);
    check("latch", 64'(latch), 64'(exp_latch));
    if (exp_latch) m_pend = 0;

    b   = s ? 0 : m_pos;
    mis = s && m_locked && (m_pos != 0);
    if (mis) m_pend = 0;
    for (int v = 0; v < NV; v++) m_hold[v][b] = mk[v] ? '0 : ln[v*LW +: LW];
    m_valid = m_locked && (b == R - 1);
    if (m_valid) begin
      for (int v = 0; v < NV; v++) begin
        for (int k = 0; k < R; k++) f[k*LW +: LW] = m_hold[v][k];
        exp_q.push_back(f);
      end
    end
    if (c) m_cnt = mis ? 1 : 0;
    else if (mis && m_cnt < 255) m_cnt++;
    m_locked = m_locked | s;
    m_pos = (b + 1) % R;

    @(posedge clk);
    #1;
    cyc_n++;
    check("valid", 64'(valid), 64'(m_valid));
    check("locked", 64'(locked), 64'(m_locked));
    check("resync_cnt", 64'(rcnt), 64'(m_cnt));
    if (m_valid) begin
      for (int v = 0; v < NV; v++) m_frame[v] = exp_q.pop_front();
    end
    for (int v = 0; v < NV; v++)
      check($sformatf("sbits[%0d]", v), sbits[frame_lsb(v, 0, LW, R) +: SW], m_frame[v]);
  endtask

  task automatic frame(input bit mkr, input logic [NV-1:0] mk, input logic [CW-1:0] ph0,
                       input logic [CW-1:0] ph1, input bit use_rnd);
    for (int b = 0; b < R; b++)
      cyc(mkr && (b == 0), mk, 1'b0, (b == 0) ? ph0 : ph1, use_rnd ? rnd_lanes() : pat(b));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_latch"}, 64'(latch), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_rcnt"}, 64'(rcnt), 64'd0);
    check({tag, "_sbits"}, 64'(|sbits), 64'd0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last_v;
    int nvalid;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // No marker yet: nothing may complete.
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, '0, rnd_lanes());

    // First marker and aligned pattern frames.
    frame(1'b1, '0, 2'd0, 2'd0, 1'b0);
    check("vfat3_frame", sbits[frame_lsb(3, 0, LW, R) +: SW], 64'h0303_0302_0301_0300);
    frame(1'b0, '0, 2'd0, 2'd0, 1'b0);
    frame(1'b1, '0, 2'd0, 2'd0, 1'b0);

    // Masked VFATs 0 and 2.
    frame(1'b0, 24'h000005, 2'd0, 2'd0, 1'b0);
    check("mask_v0", sbits[frame_lsb(0, 0, LW, R) +: SW], 64'd0);
    check("mask_v2", sbits[frame_lsb(2, 0, LW, R) +: SW], 64'd0);
    check("mask_v1", sbits[frame_lsb(1, 0, LW, R) +: SW], 64'h0103_0102_0101_0100);
    check("mask_v3", sbits[frame_lsb(3, 0, LW, R) +: SW], 64'h0303_0302_0301_0300);

    // Latch phases, including mid-frame phase changes.
    frame(1'b0, '0, 2'd1, 2'd1, 1'b0);
    frame(1'b0, '0, 2'd3, 2'd0, 1'b0);
    frame(1'b0, '0, 2'd0, 2'd3, 1'b0);
    frame(1'b0, '0, 2'd3, 2'd1, 1'b0);
    frame(1'b0, '0, 2'd1, 2'd1, 1'b0);

    // Misaligned marker at beat 2.
    cyc(1'b0, '0, 1'b0, 2'd0, pat(0));
    cyc(1'b0, '0, 1'b0, 2'd0, pat(1));
    cyc(1'b1, '0, 1'b0, 2'd0, pat(0));
    check("resync_one", 64'(rcnt), 64'd1);
    for (int b = 1; b < R; b++) cyc(1'b0, '0, 1'b0, 2'd0, pat(b));
    frame(1'b0, '0, 2'd2, 2'd2, 1'b0);

    // Saturation of the resync counter.
    for (int i = 0; i < 260; i++) begin
      cyc(1'b1, '0, 1'b0, 2'd0, rnd_lanes());
      cyc(1'b0, '0, 1'b0, 2'd0, rnd_lanes());
    end
    check("resync_sat", 64'(rcnt), 64'd255);
    cyc(1'b1, '0, 1'b1, 2'd0, rnd_lanes());
    check("clr_with_mis", 64'(rcnt), 64'd1);
    cyc(1'b0, '0, 1'b1, 2'd0, rnd_lanes());
    check("clr_alone", 64'(rcnt), 64'd0);
    frame(1'b1, '0, 2'd0, 2'd0, 1'b1);
    frame(1'b0, '0, 2'd0, 2'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) == 0,
          ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0,
          $urandom_range(0, 31) == 0,
          CW'($urandom_range(0, R - 1)),
          rnd_lanes());

    // Reset mid-frame, then no relock without a marker.
    frame(1'b1, '0, 2'd1, 2'd1, 1'b1);
    cyc(1'b0, '0, 1'b0, 2'd1, rnd_lanes());
    cyc(1'b0, '0, 1'b0, 2'd1, rnd_lanes());
    mid_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, NV'($urandom), 1'b0, 2'd0, rnd_lanes());
    check("no_relock", 64'(locked), 64'd0);
    frame(1'b1, '0, 2'd2, 2'd2, 1'b1);
    frame(1'b0, '0, 2'd0, 2'd0, 1'b0);
    frame(1'b0, '0, 2'd0, 2'd0, 1'b1);

    // 8 VFATs x 8 bits x 8 beats instance: period and layout.
    last_v = -1;
    nvalid = 0;
    for (int t = 0; t < 3 * R2 + 2; t++) begin
      sync2  = (t == 0);
      lanes2 = pat2(t % R2);
      @(posedge clk);
      #1;
      if (valid2) begin
        nvalid++;
        if (last_v >= 0) check("period8", 64'(t - last_v), 64'(R2));
        else check("first_valid8", 64'(t), 64'(R2 - 1));
        last_v = t;
        for (int v = 0; v < NV2; v++)
          for (int b = 0; b < R2; b++)
            check($sformatf("layout8_v%0d_b%0d", v, b),
                  64'(sbits2[frame_lsb(v, b, LW2, R2) +: LW2]), 64'({4'(v), 4'(b)}));
      end
    end
    check("nvalid8", 64'(nvalid), 64'd3);
    sync2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
